// File: rtl/pipe_wb_trace_monitor_if.sv
// Trace drain channel of the writeback monitor: show-ahead head entry with valid/ready.
// The monitor is the master (it offers entries); the consumer is the slave.
interface pipe_wb_trace_monitor_if #(
  parameter int DW  = 32,
  parameter int RAW = 5,
  parameter int CW  = 16
);
  logic           trace_valid;
  logic           trace_ready;
  logic [RAW-1:0] trace_rd;
  logic [DW-1:0]  trace_data;
  logic [CW-1:0]  trace_ts;

  modport master (output trace_valid, trace_rd, trace_data, trace_ts, input trace_ready);
  modport slave  (input trace_valid, trace_rd, trace_data, trace_ts, output trace_ready);
endinterface

// File: rtl/pipe_wb_trace_monitor.sv
// Writeback-stage monitor: traces writes to watched registers into a timestamped
// show-ahead FIFO and keeps saturating cycle/retire/stall/flush/drop counters.
module pipe_wb_trace_monitor #(
  parameter int  DW        = 32,
  parameter int  RAW       = 5,
  parameter int  DEPTH     = 8,
  parameter int  CW        = 16,
  parameter bit  IGNORE_R0 = 1'b1,
  localparam int NREG      = 2**RAW,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  RegWrite_WB,
  input  logic [RAW-1:0]        Rdfinal,
  input  logic [DW-1:0]         wB_Data_final,
  input  logic                  stall_HDU,
  input  logic                  flush,
  input  logic [NREG-1:0]       watch_mask,
  pipe_wb_trace_monitor_if.master trace,
  output logic [CW-1:0]         cycle_cnt,
  output logic [CW-1:0]         retire_cnt,
  output logic [CW-1:0]         stall_cnt,
  output logic [CW-1:0]         flush_cnt,
  output logic [CW-1:0]         drop_cnt,
  output logic [LW-1:0]         fifo_level
);

  typedef struct packed {
    logic [CW-1:0]  ts;
    logic [DW-1:0]  data;
    logic [RAW-1:0] rd;
  } entry_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CW'(1) : v;
  endfunction

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d, retire_cnt_q, retire_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          wr_evt, trace_evt, valid, full, pop, push, drop;

  assign wr_evt    = RegWrite_WB & ~(IGNORE_R0 & (Rdfinal == '0));
  assign trace_evt = en & wr_evt & watch_mask[Rdfinal];
  assign level     = wr_ptr_q - rd_ptr_q;
  assign valid     = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = valid & trace.trace_ready;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push      = trace_evt & ~clr & (~full | pop);
  assign drop      = trace_evt & ~clr & full & ~pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (clr) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      cycle_cnt_d  = '0;
      retire_cnt_d = '0;
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      drop_cnt_d   = '0;
    end else begin
      cycle_cnt_d  = sat_inc(cycle_cnt_q,  en);
      retire_cnt_d = sat_inc(retire_cnt_q, en & wr_evt);
      stall_cnt_d  = sat_inc(stall_cnt_q,  en & stall_HDU);
      flush_cnt_d  = sat_inc(flush_cnt_q,  en & flush);
      drop_cnt_d   = sat_inc(drop_cnt_q,   drop);
      if (push) wr_ptr_d = wr_ptr_q + LW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // NOTE: storage is not reset; the head is masked by valid so stale words never show.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{ts: cycle_cnt_q, data: wB_Data_final, rd: Rdfinal};
  end

  assign head              = mem_q[rd_ptr_q[AW-1:0]];
  assign trace.trace_valid = valid;
  assign trace.trace_rd    = valid ? head.rd   : '0;
  assign trace.trace_data  = valid ? head.data : '0;
  assign trace.trace_ts    = valid ? head.ts   : '0;

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level;

endmodule

// File: doc/pipe_wb_trace_monitor.md
Name: pipe_wb_trace_monitor

Overview:
Synthesizable, parametrised monitor that observes the writeback stage of the 5-stage pipeline and the hazard/flush controls. Captures register writes to a selectable set of registers into a timestamped trace FIFO with a valid/ready drain port. Maintains saturating performance counters for cycles, retired writes, stalls, flushes and dropped trace entries. It replaces single-register console monitoring with an N-register trace that benches and on-chip debug logic can drain.

Parameters:
DW, 32, writeback data width
RAW, 5, register address width; NREG = 2**RAW
DEPTH, 8, trace FIFO entries; power of two, >= 2
CW, 16, width of every counter and of the timestamp
IGNORE_R0, 1, when 1, writes to register 0 are neither traced nor counted as retired

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  monitor enable; when 0, no counter increments and no enqueue
clr  in  1  synchronous clear of counters and FIFO
RegWrite_WB  in  1  writeback write enable
Rdfinal  in  RAW  writeback destination register
wB_Data_final  in  DW  writeback data
stall_HDU  in  1  hazard-unit stall this cycle
flush  in  1  pipeline flush this cycle
watch_mask  in  NREG  bit i=1 selects register i for tracing
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_rd  out  RAW  head register address
trace_data  out  DW  head write data
trace_ts  out  CW  head timestamp
cycle_cnt  out  CW  enabled cycles
retire_cnt  out  CW  counted writebacks
stall_cnt  out  CW  stall cycles
flush_cnt  out  CW  flush cycles
drop_cnt  out  CW  trace entries lost to a full FIFO
fifo_level  out  log2(DEPTH)+1  current occupancy

Behaviour:
- reset low: all counters 0, FIFO empty, trace_valid=0, trace_rd/trace_data/trace_ts=0, fifo_level=0. Takes effect immediately, independent of clk. Reset mid-drain discards all entries.
- wr_evt = RegWrite_WB & ~(IGNORE_R0 & Rdfinal==0).
- trace_evt = en & wr_evt & watch_mask[Rdfinal].
- When en=1, per cycle:
  - cycle_cnt += 1
  - retire_cnt += wr_evt
  - stall_cnt += stall_HDU
  - flush_cnt += flush
- All counters saturate at 2**CW-1 and never wrap.
- Timestamp stored with an entry = cycle_cnt value sampled in the event cycle, before that cycle's increment.
- FIFO is show-ahead:
  - trace_* show the head combinationally from storage; trace_valid = (level != 0).
  - pop = trace_valid & trace_ready.
  - Head data must remain stable while trace_valid=1 and trace_ready=0.
- Enqueue latency: an event in cycle t is visible at the head no earlier than t+1, i.e. trace_valid rises the cycle after an enqueue into an empty FIFO.
- Full (level==DEPTH):
  - trace_evt with pop in the same cycle: accepted; level unchanged.
  - trace_evt without pop: entry dropped; drop_cnt += 1 (saturating).
- Empty: trace_ready is ignored; no underflow.
- Simultaneous enqueue and pop at any non-full level: level unchanged.
- Read and write pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.
- clr=1 (synchronous):
  - all counters and fifo_level go to 0 and the FIFO empties on the next edge.
  - clr has priority over every event in the same cycle; that cycle's events are neither counted nor enqueued.
- en=0: the FIFO still drains on pop; counters hold.

Test Plan:
1. Release reset, en=1, watch_mask=1<<8, write R8=0x0000_00AA at cycle 3 -> trace_valid=1 at cycle 4 with trace_rd=8, trace_data=0xAA, trace_ts=3; retire_cnt=1.
2. Writes to R5 (unmasked) and R0 (IGNORE_R0=1) -> no trace entry. retire_cnt increments for R5 only.
3. trace_ready=0, 10 traced writes, DEPTH=8 -> fifo_level=8, drop_cnt=2. Drain yields the first 8 entries in order with stable head while stalled.
4. FIFO full, trace_evt and pop in the same cycle -> level stays 8, drop_cnt unchanged, new entry appears last in the drain.
5. stall_HDU high 3 cycles, flush high 1 cycle, then clr coincident with a traced write -> stall_cnt=3, flush_cnt=1 before clr; all counters 0 and FIFO empty after, write not traced. CW=4 over 20 cycles -> cycle_cnt holds at 15.
6. Assert reset low asynchronously mid-drain with 5 entries -> trace_valid and all counters 0 before the next clk edge.
